door_system: RTL and testbench

// Keypad door lock controller. Accepts a 4-digit code from a 4-bit keypad bus.

---
 rtl/door_system.sv | 145 ++++++++++++++
 tb/tb_door_system.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/door_system.sv
// Keypad door lock: four-digit code entry with per-digit timeout, timed unlock
// and timed error indication. Outputs are registered decodes of the FSM state.
module door_system #(
    parameter logic [3:0]  PASS0       = 4'd1,
    parameter logic [3:0]  PASS1       = 4'd3,
    parameter logic [3:0]  PASS2       = 4'd2,
    parameter logic [3:0]  PASS3       = 4'd4,
    parameter int unsigned TIMEOUT     = 10,
    parameter int unsigned OPEN_CYCLES = 20,
    parameter int unsigned ERR_CYCLES  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic       y,
    output logic       green,
    output logic       red
);

    localparam int unsigned MAX_AB = (TIMEOUT > OPEN_CYCLES) ? TIMEOUT : OPEN_CYCLES;
    localparam int unsigned MAX_C  = (MAX_AB > ERR_CYCLES) ? MAX_AB : ERR_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] ERR_LAST  = CW'(ERR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StOpen,
        StError
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          mismatch;
    logic [3:0]    btn_q;
    logic [3:0]    btn_prev;
    logic          press;
    logic [3:0]    pass_digit;
    logic          miss_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q    <= 4'd0;
            btn_prev <= 4'd0;
        end else begin
            btn_q    <= btn;
            btn_prev <= btn_q;
        end
    end

    // A held key is one press; a direct change between nonzero keys is a new one.
    always_comb begin
        press = (btn_q != 4'd0) && (btn_q != btn_prev);
    end

    always_comb begin
        pass_digit = PASS0;
        unique case (idx)
            2'd0: pass_digit = PASS0;
            2'd1: pass_digit = PASS1;
            2'd2: pass_digit = PASS2;
            2'd3: pass_digit = PASS3;
        endcase
        miss_now = mismatch | (btn_q != pass_digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            cnt      <= '0;
            idx      <= 2'd0;
            mismatch <= 1'b0;
            y        <= 1'b0;
            green    <= 1'b0;
            red      <= 1'b0;
        end else begin
            // Outputs follow the state register one edge later.
            y     <= (state == StOpen);
            green <= (state == StOpen);
            red   <= (state == StError);

            unique case (state)
                StIdle: begin
                    if (press) begin
                        mismatch <= (btn_q != PASS0);
                        idx      <= 2'd1;
                        cnt      <= '0;
                        state    <= StEntry;
                    end
                end

                StEntry: begin
                    if (press) begin
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            // Verdict only after the last digit, never earlier.
                            idx      <= 2'd0;
                            mismatch <= 1'b0;
                            state    <= miss_now ? StError : StOpen;
                        end else begin
                            mismatch <= miss_now;
                            idx      <= idx + 2'd1;
                        end
                    end else if (cnt >= TO_LAST) begin
                        cnt      <= '0;
                        idx      <= 2'd0;
                        mismatch <= 1'b0;
                        state    <= StError;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                StOpen: begin
                    if (cnt >= OPEN_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                StError: begin
                    if (cnt >= ERR_LAST) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_system.sv
// Scoreboard bench for door_system: stimulus queues expected output events
// (value, onset cycle, duration); a negedge monitor checks every output change.
module tb_door_system;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'd0;
    logic [3:0] btn2 = 4'd0;
    logic       y, green, red;
    logic       y2, green2, red2;
    logic [5:0] out_vec;

    always #5 clk = ~clk;

    door_system dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .y     (y),
        .green (green),
        .red   (red)
    );

    door_system #(
        .PASS0 (4'd5),
        .PASS1 (4'd5),
        .PASS2 (4'd6),
        .PASS3 (4'd7)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .btn   (btn2),
        .y     (y2),
        .green (green2),
        .red   (red2)
    );

    assign out_vec = {y2, green2, red2, y, green, red};

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_OPEN1 = 6'b000110;
    localparam logic [5:0] O_ERR1  = 6'b000001;
    localparam logic [5:0] O_OPEN2 = 6'b110000;
    localparam logic [5:0] O_ERR2  = 6'b001000;

    typedef struct {
        logic [5:0] v;
        int         start;
        int         len;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    bit         seg_live = 1'b0;
    int         seg_start = 0;
    int         seg_len = 0;
    logic [5:0] prev_out = 6'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input logic [5:0] v, input int start, input int len);
        exp_t e;
        e.v     = v;
        e.start = start;
        e.len   = len;
        q.push_back(e);
    endtask

    // Monitor: every change of the output vector consumes one expected event.
    always @(negedge clk) begin
        if (mon_en && out_vec !== prev_out) begin
            if (seg_live && seg_len != 0) check("segment length", cyc - seg_start, seg_len);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected change: got %b, want %b (cycle %0d)",
                         out_vec, prev_out, cyc);
                seg_live = 1'b0;
            end else begin
                me = q.pop_front();
                check("output value", int'(out_vec), int'(me.v));
                check("onset cycle", cyc, me.start);
                seg_len  = me.len;
                seg_live = 1'b1;
            end
            seg_start = cyc;
            prev_out  = out_vec;
        end
    end

    task automatic key(input bit sel, input logic [3:0] v, input int hold, output int k);
        if (sel) btn2 = v;
        else btn = v;
        k = cyc;
        repeat (hold) @(negedge clk);
    endtask

    task automatic rest(input int n);
        btn  = 4'd0;
        btn2 = 4'd0;
        repeat (n) @(negedge clk);
    endtask

    int k;
    int d;

    initial begin
        #1 reset = 1'b0;
        #1 check("reset outputs", int'(out_vec), 0);
        prev_out = 6'b0;
        mon_en   = 1'b1;
        repeat (3) @(negedge clk);
        check("outputs held in reset", int'(out_vec), 0);
        reset = 1'b1;
        rest(2);

        // 1: correct code opens for 20 cycles
        key(0, 4'd1, 2, k); key(0, 4'd3, 2, k); key(0, 4'd2, 2, k); key(0, 4'd4, 2, k);
        expect_ev(O_OPEN1, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);

        // 2: wrong code shows red for 20 cycles
        key(0, 4'd1, 2, k); key(0, 4'd2, 2, k); key(0, 4'd3, 2, k); key(0, 4'd4, 2, k);
        expect_ev(O_ERR1, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);

        // 3: abandoned entry times out; presses during red are ignored
        key(0, 4'd1, 2, k); key(0, 4'd3, 2, k);
        expect_ev(O_ERR1, k + 13, 20);
        expect_ev(O_IDLE, k + 33, 0);
        rest(14);
        key(0, 4'd1, 2, d); key(0, 4'd3, 2, d); key(0, 4'd2, 2, d); key(0, 4'd4, 2, d);
        rest(40);

        // 4: long hold counts once; repeated key without release is not a new digit
        key(0, 4'd1, 8, k); key(0, 4'd3, 2, k); key(0, 4'd2, 2, k); key(0, 4'd4, 2, k);
        expect_ev(O_OPEN1, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);
        key(0, 4'd1, 2, k); key(0, 4'd1, 2, k); key(0, 4'd3, 2, k); key(0, 4'd2, 2, k);
        expect_ev(O_ERR1, k + 13, 20);
        expect_ev(O_IDLE, k + 33, 0);
        rest(40);

        // 5: asynchronous reset while open, then reopen
        key(0, 4'd1, 2, k); key(0, 4'd3, 2, k); key(0, 4'd2, 2, k); key(0, 4'd4, 2, k);
        expect_ev(O_OPEN1, k + 3, 5);
        expect_ev(O_IDLE, k + 8, 0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("async reset clears outputs", int'(out_vec), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rest(2);
        key(0, 4'd1, 2, k); key(0, 4'd3, 2, k); key(0, 4'd2, 2, k); key(0, 4'd4, 2, k);
        expect_ev(O_OPEN1, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);

        // 6: overridden password 5,5,6,7 on the second instance
        key(1, 4'd5, 2, k); key(1, 4'd0, 1, k); key(1, 4'd5, 2, k);
        key(1, 4'd6, 2, k); key(1, 4'd7, 2, k);
        expect_ev(O_OPEN2, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);
        key(1, 4'd1, 2, k); key(1, 4'd3, 2, k); key(1, 4'd2, 2, k); key(1, 4'd4, 2, k);
        expect_ev(O_ERR2, k + 3, 20);
        expect_ev(O_IDLE, k + 23, 0);
        rest(40);

        check("scoreboard drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
